// File: rtl/fpu_muldiv_iter_if.sv
// Handshake bundle for the iterative FP multiply/divide engine: operand request channel
// (in_valid/in_ready) and result channel (out_valid/out_ready).
interface fpu_muldiv_iter_if #(
  parameter int unsigned W = 64
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fpu_muldiv_iter.sv
// Iterative IEEE-754 multiply (shift-add) / divide (restoring), one bit per cycle.
// Define FPU_ITER_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fpu_muldiv_iter #(
  parameter int unsigned EXP_W = 11,
  parameter int unsigned MAN_W = 52
) (
  input logic              clk,
  input logic              rst,
  fpu_muldiv_iter_if.slave bus
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned M  = MAN_W + 1;
  localparam int unsigned Q  = MAN_W + 3;
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned CW = $clog2(Q + 1);
  localparam logic signed [EW-1:0] Bias   = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] ExpMax = EW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {StIdle, StUnpack, StIter, StNorm, StRound, StDone} state_e;

  state_e state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic           op_q, op_d, sign_q, sign_d;
  logic [4:0]     flags_q, flags_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*M-1:0] acc_q, acc_d, acc_src, acc_step;
  logic [M-1:0]   mplr_q, mplr_d, mplr_src, mplr_step;
  logic [M:0]     rem_q, rem_d, rem_src, rem_sub, rem_step;
  logic [Q-1:0]   quo_q, quo_d, quo_src, quo_step;
  logic [M-1:0]   man_q, man_d;
  logic           g_q, g_d, r_q, r_d, s_q, s_d;
  logic signed [EW-1:0] exp_q, exp_d, ea_x, eb_x, exp_rnd;

  logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, rem_ge, last_iter;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb, frac_rnd;
  logic [M-1:0]     ma, mb;
  logic             special, round_up, inexact;
  logic [W-1:0]     special_res, qnan, inf_res, zero_res;
  logic [4:0]       special_flags;
  logic [M:0]       man_inc;

  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);
  assign ma     = {1'b1, fa};
  assign mb     = {1'b1, fb};
  assign ea_x   = {2'b00, ea};
  assign eb_x   = {2'b00, eb};

  assign qnan     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
  assign inf_res  = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign zero_res = {sa ^ sb, {(W - 1){1'b0}}};

  // Subnormals count as zero here, so flushing falls out of the zero tests.
  always_comb begin
    special       = 1'b1;
    special_res   = zero_res;
    special_flags = '0;
    if (a_nan || b_nan) begin
      special_res = qnan;
    end else if (!op_q) begin
      if ((a_zero && b_inf) || (a_inf && b_zero)) begin
        special_res   = qnan;
        special_flags = 5'b10000;
      end else if (a_inf || b_inf) begin
        special_res = inf_res;
      end else if (!(a_zero || b_zero)) begin
        special = 1'b0;
      end
    end else begin
      if ((a_inf && b_inf) || (a_zero && b_zero)) begin
        special_res   = qnan;
        special_flags = 5'b10000;
      end else if (a_inf) begin
        special_res = inf_res;
      end else if (b_zero) begin
        special_res   = inf_res;
        special_flags = 5'b01000;
      end else if (!(b_inf || a_zero)) begin
        special = 1'b0;
      end
    end
  end

  // UNPACK performs the first iteration from the raw operands, ITER the remaining N-1.
  assign acc_src   = (state_q == StUnpack) ? '0 : acc_q;
  assign mplr_src  = (state_q == StUnpack) ? mb : mplr_q;
  assign rem_src   = (state_q == StUnpack) ? {1'b0, ma} : rem_q;
  assign quo_src   = (state_q == StUnpack) ? '0 : quo_q;
  assign acc_step  = (acc_src << 1) + (mplr_src[M-1] ? {{M{1'b0}}, ma} : '0);
  assign mplr_step = mplr_src << 1;
  assign rem_ge    = (rem_src >= {1'b0, mb});
  assign rem_sub   = rem_ge ? (rem_src - {1'b0, mb}) : rem_src;
  assign rem_step  = rem_sub << 1;
  assign quo_step  = (quo_src << 1) | Q'(rem_ge);
  assign last_iter = (count_q == CW'(op_q ? Q - 1 : M - 1));

`ifdef FPU_ITER_RNE_EN
  assign round_up = g_q && (r_q || s_q || man_q[0]);
`else
  assign round_up = 1'b0;
`endif
  assign man_inc  = {1'b0, man_q} + (M + 1)'(round_up);
  assign frac_rnd = man_inc[M] ? man_inc[MAN_W:1] : man_inc[MAN_W-1:0];
  assign exp_rnd  = exp_q + EW'(man_inc[M]);
  assign inexact  = g_q || r_q || s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.in_valid) state_d = StUnpack;
      StUnpack: state_d = special ? StDone : StIter;
      StIter:   if (last_iter) state_d = StNorm;
      StNorm:   state_d = StRound;
      StRound:  state_d = StDone;
      StDone:   if (bus.out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.result    = result_q;
    bus.flags     = flags_q;
  end

  always_comb begin
    a_d = a_q;       b_d = b_q;       op_d = op_q;     count_d = count_q;
    acc_d = acc_q;   mplr_d = mplr_q; rem_d = rem_q;   quo_d = quo_q;
    man_d = man_q;   g_d = g_q;       r_d = r_q;       s_d = s_q;
    exp_d = exp_q;   sign_d = sign_q; result_d = result_q; flags_d = flags_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d = bus.a;  b_d = bus.b;  op_d = bus.op;
          result_d = '0;  flags_d = '0;  count_d = '0;
        end
      end
      StUnpack: begin
        sign_d = sa ^ sb;
        exp_d  = op_q ? (ea_x - eb_x + Bias) : (ea_x + eb_x - Bias);
        if (special) begin
          result_d = special_res;
          flags_d  = special_flags;
        end else begin
          count_d = CW'(1);
          acc_d = acc_step;  mplr_d = mplr_step;  rem_d = rem_step;  quo_d = quo_step;
        end
      end
      StIter: begin
        count_d = count_q + CW'(1);
        acc_d = acc_step;  mplr_d = mplr_step;  rem_d = rem_step;  quo_d = quo_step;
      end
      StNorm: begin
        if (!op_q) begin
          if (acc_q[2*M-1]) begin
            man_d = acc_q[2*M-1 -: M];  g_d = acc_q[M-1];  r_d = acc_q[M-2];
            s_d = |acc_q[M-3:0];  exp_d = exp_q + EW'(1);
          end else begin
            man_d = acc_q[2*M-2 -: M];  g_d = acc_q[M-2];  r_d = acc_q[M-3];
            s_d = |acc_q[M-4:0];
          end
        end else if (quo_q[Q-1]) begin
          man_d = quo_q[Q-1 -: M];  g_d = quo_q[1];  r_d = quo_q[0];  s_d = |rem_q;
        end else begin
          // Quotient below 1: the round bit is folded into sticky via the remainder.
          man_d = quo_q[Q-2:1];  g_d = quo_q[0];  r_d = 1'b0;  s_d = |rem_q;
          exp_d = exp_q - EW'(1);
        end
      end
      StRound: begin
        if (exp_rnd >= ExpMax) begin
`ifdef FPU_ITER_RNE_EN
          result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
          result_d = {sign_q, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
          flags_d = 5'b00101;
        end else if (exp_rnd <= 0) begin
          result_d = {sign_q, {(W - 1){1'b0}}};
          flags_d  = 5'b00011;
        end else begin
          result_d = {sign_q, exp_rnd[EXP_W-1:0], frac_rnd};
          flags_d  = {4'b0000, inexact};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;    b_q <= '0;    op_q <= 1'b0;  count_q <= '0;
      acc_q <= '0;  mplr_q <= '0; rem_q <= '0;   quo_q <= '0;
      man_q <= '0;  g_q <= 1'b0;  r_q <= 1'b0;   s_q <= 1'b0;
      exp_q <= '0;  sign_q <= 1'b0; result_q <= '0; flags_q <= '0;
    end else begin
      a_q <= a_d;     b_q <= b_d;       op_q <= op_d;   count_q <= count_d;
      acc_q <= acc_d; mplr_q <= mplr_d; rem_q <= rem_d; quo_q <= quo_d;
      man_q <= man_d; g_q <= g_d;       r_q <= r_d;     s_q <= s_d;
      exp_q <= exp_d; sign_q <= sign_d; result_q <= result_d; flags_q <= flags_d;
    end
  end
endmodule

// File: tb/tb_fpu_muldiv_iter.sv
// Scoreboard bench for fpu_muldiv_iter: double and half instances, directed vectors,
// latency counted in rising edges with the accept edge as edge 1.
module tb_fpu_muldiv_iter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_muldiv_iter_if #(.W(64)) bd ();
  fpu_muldiv_iter_if #(.W(16)) bh ();

  fpu_muldiv_iter #(.EXP_W(11), .MAN_W(52)) u_dut_d (.clk(clk), .rst(rst), .bus(bd));
  fpu_muldiv_iter #(.EXP_W(5),  .MAN_W(10)) u_dut_h (.clk(clk), .rst(rst), .bus(bh));

`ifdef FPU_ITER_RNE_EN
  localparam logic [63:0] OvfD = 64'h7FF0000000000000;
  localparam logic [63:0] RndD = 64'h3FF8000000000002;
  localparam logic [15:0] OvfH = 16'h7C00;
`else
  localparam logic [63:0] OvfD = 64'h7FEFFFFFFFFFFFFF;
  localparam logic [63:0] RndD = 64'h3FF8000000000001;
  localparam logic [15:0] OvfH = 16'h7BFF;
`endif

  typedef struct {
    logic [63:0] res;
    logic [4:0]  fl;
    int          lat;
    string       nm;
  } exp_t;

  exp_t qd[$];
  exp_t qh[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitors: pop one expectation per result, on the first cycle out_valid is seen.
  int d_edges, h_edges;
  bit d_busy, d_seen, h_busy, h_seen;
  always begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      d_busy = 1'b0;  d_seen = 1'b0;
    end else begin
      if (d_busy) d_edges++;
      if (bd.out_valid && !d_seen) begin
        d_seen = 1'b1;
        if (qd.size() == 0) begin
          check("d_unexpected_out_valid", 64'(bd.out_valid), 64'd0);
        end else begin
          e = qd.pop_front();
          check({e.nm, "_result"}, bd.result, e.res);
          check({e.nm, "_flags"}, 64'(bd.flags), 64'(e.fl));
          check({e.nm, "_latency"}, 64'(d_edges), 64'(e.lat));
        end
      end
      if (bd.out_valid && bd.out_ready) begin d_busy = 1'b0; d_seen = 1'b0; end
      if (bd.in_valid && bd.in_ready) begin d_busy = 1'b1; d_edges = 0; end
    end
  end

  always begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      h_busy = 1'b0;  h_seen = 1'b0;
    end else begin
      if (h_busy) h_edges++;
      if (bh.out_valid && !h_seen) begin
        h_seen = 1'b1;
        if (qh.size() == 0) begin
          check("h_unexpected_out_valid", 64'(bh.out_valid), 64'd0);
        end else begin
          e = qh.pop_front();
          check({e.nm, "_result"}, 64'(bh.result), e.res);
          check({e.nm, "_flags"}, 64'(bh.flags), 64'(e.fl));
          check({e.nm, "_latency"}, 64'(h_edges), 64'(e.lat));
        end
      end
      if (bh.out_valid && bh.out_ready) begin h_busy = 1'b0; h_seen = 1'b0; end
      if (bh.in_valid && bh.in_ready) begin h_busy = 1'b1; h_edges = 0; end
    end
  end

  task automatic drive_d(input string nm, input logic op, input logic [63:0] a, b, output bit ok);
    int g = 0;
    while (!bd.in_ready && g < 300) begin @(posedge clk); #1; g++; end
    check({nm, "_accept_wait"}, 64'(bd.in_ready), 64'd1);
    ok = bd.in_ready;
    if (ok) begin
      bd.a = a;  bd.b = b;  bd.op = op;  bd.in_valid = 1'b1;
      @(posedge clk); #1;
      bd.in_valid = 1'b0;
    end
  endtask

  task automatic issue_d(input string nm, input logic op, input logic [63:0] a, b, res,
                         input logic [4:0] fl, input int lat);
    exp_t e;
    bit   ok;
    e.res = res;  e.fl = fl;  e.lat = lat;  e.nm = nm;
    qd.push_back(e);
    drive_d(nm, op, a, b, ok);
    if (!ok) void'(qd.pop_back());
  endtask

  task automatic issue_h(input string nm, input logic op, input logic [15:0] a, b, res,
                         input logic [4:0] fl, input int lat);
    exp_t e;
    int   g = 0;
    while (!bh.in_ready && g < 300) begin @(posedge clk); #1; g++; end
    check({nm, "_accept_wait"}, 64'(bh.in_ready), 64'd1);
    if (bh.in_ready) begin
      e.res = 64'(res);  e.fl = fl;  e.lat = lat;  e.nm = nm;
      qh.push_back(e);
      bh.a = a;  bh.b = b;  bh.op = op;  bh.in_valid = 1'b1;
      @(posedge clk); #1;
      bh.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string nm);
    int g = 0;
    while (!(qd.size() == 0 && qh.size() == 0 && bd.in_ready && bh.in_ready) && g < 400) begin
      @(posedge clk); #1; g++;
    end
    check({nm, "_drain"}, 64'(qd.size() + qh.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int g;
    rst = 1'b1;
    bd.in_valid = 1'b0;  bd.a = '0;  bd.b = '0;  bd.op = 1'b0;  bd.out_ready = 1'b1;
    bh.in_valid = 1'b0;  bh.a = '0;  bh.b = '0;  bh.op = 1'b0;  bh.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready",  64'(bd.in_ready),  64'd1);
    check("reset_out_valid", 64'(bd.out_valid), 64'd0);
    check("reset_result",    bd.result,         64'd0);
    check("reset_flags",     64'(bd.flags),     64'd0);
    check("reset_h_in_ready", 64'(bh.in_ready), 64'd1);

    issue_d("mul_1p5x2",  1'b0, 64'h3FF8000000000000, 64'h4000000000000000,
            64'h4008000000000000, 5'b00000, 56);
    issue_d("div_1by3",   1'b1, 64'h3FF0000000000000, 64'h4008000000000000,
            64'h3FD5555555555555, 5'b00001, 58);
    issue_d("div_by_0",   1'b1, 64'h3FF0000000000000, 64'h0000000000000000,
            64'h7FF0000000000000, 5'b01000, 2);
    issue_d("div_0by0",   1'b1, 64'h0000000000000000, 64'h0000000000000000,
            64'h7FF8000000000000, 5'b10000, 2);
    issue_d("mul_ovf",    1'b0, 64'h7FE0000000000000, 64'h4000000000000000,
            OvfD, 5'b00101, 56);
    issue_d("mul_neg",    1'b0, 64'hBFF8000000000000, 64'h4000000000000000,
            64'hC008000000000000, 5'b00000, 56);
    issue_d("mul_unf",    1'b0, 64'h0010000000000000, 64'h0010000000000000,
            64'h0000000000000000, 5'b00011, 56);
    issue_d("mul_tie",    1'b0, 64'h3FF0000000000001, 64'h3FF8000000000000,
            RndD, 5'b00001, 56);
    issue_d("mul_nan",    1'b0, 64'h7FF0000000000001, 64'h3FF0000000000000,
            64'h7FF8000000000000, 5'b00000, 2);
    issue_d("mul_inf_0",  1'b0, 64'h7FF0000000000000, 64'h0000000000000000,
            64'h7FF8000000000000, 5'b10000, 2);
    issue_d("div_x_inf",  1'b1, 64'hBFF0000000000000, 64'h7FF0000000000000,
            64'h8000000000000000, 5'b00000, 2);
    issue_d("div_neg_0",  1'b1, 64'hBFF0000000000000, 64'h0000000000000000,
            64'hFFF0000000000000, 5'b01000, 2);
    issue_d("mul_subn",   1'b0, 64'h0000000000000001, 64'h4000000000000000,
            64'h0000000000000000, 5'b00000, 2);
    issue_h("h_mul",      1'b0, 16'h3E00, 16'h4000, 16'h4200, 5'b00000, 14);
    issue_h("h_ovf",      1'b0, 16'h7BFF, 16'h4000, OvfH, 5'b00101, 14);
    issue_h("h_div_1by3", 1'b1, 16'h3C00, 16'h4200, 16'h3555, 5'b00001, 16);
    wait_drain("vectors");

    // Backpressure: result held, new requests ignored while out_ready stays low.
    bd.out_ready = 1'b0;
    issue_d("bp_mul", 1'b0, 64'h3FF8000000000000, 64'h4000000000000000,
            64'h4008000000000000, 5'b00000, 56);
    g = 0;
    while (!bd.out_valid && g < 100) begin @(posedge clk); #1; g++; end
    check("bp_out_valid_seen", 64'(bd.out_valid), 64'd1);
    bd.a = 64'h4000000000000000;  bd.b = 64'h4000000000000000;  bd.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_result",    bd.result,          64'h4008000000000000);
      check("bp_flags",     64'(bd.flags),      64'd0);
      check("bp_in_ready",  64'(bd.in_ready),   64'd0);
      check("bp_out_valid", 64'(bd.out_valid),  64'd1);
    end
    bd.in_valid  = 1'b0;
    bd.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 64'(bd.out_valid), 64'd0);
    check("bp_release_in_ready",  64'(bd.in_ready),  64'd1);

    // Reset during ITER aborts the operation; nothing may emerge afterwards.
    drive_d("abort_mul", 1'b0, 64'h3FF8000000000000, 64'h4000000000000000, ok);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", 64'(bd.out_valid), 64'd0);
    check("abort_in_ready",  64'(bd.in_ready),  64'd1);
    check("abort_flags",     64'(bd.flags),     64'd0);
    repeat (80) @(posedge clk);
    #1;
    check("abort_quiet_out_valid", 64'(bd.out_valid), 64'd0);

    issue_d("post_abort_mul", 1'b0, 64'h3FF8000000000000, 64'h4000000000000000,
            64'h4008000000000000, 5'b00000, 56);
    wait_drain("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_muldiv_iter.md
Name: fpu_muldiv_iter

Overview:
- Parametrised, multi-cycle IEEE-754 multiply/divide engine. It is the next-generation iterative replacement for the combinational double-precision mul/div paths.
- Format width is set by EXP_W/MAN_W (half, single or double).
- Multiply uses shift-add, one bit per cycle; divide uses restoring division, one quotient bit per cycle.
- Adds a valid/ready handshake, exception flags and correct rounding. Sits behind the FPU op decoder; one operation in flight at a time.

Parameters:
EXP_W, 11, exponent field width; BIAS = 2^(EXP_W-1)-1
MAN_W, 52, stored fraction width; total word W = 1+EXP_W+MAN_W

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands/op present
in_ready  out  1  engine idle, can accept
a  in  W  operand A (dividend)
b  in  W  operand B (divisor)
op  in  1  0 = multiply, 1 = divide
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  W  packed IEEE result
flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; result=0; flags=0; iteration counter=0. Reset mid-operation aborts the operation and discards it; in_ready=1 on the cycle after the rst edge.
- in_ready = (state==IDLE). Accept happens on an edge where in_valid && in_ready; a, b and op are registered on that edge.
- States:
  - IDLE -> UNPACK (on accept)
  - UNPACK -> DONE (special case) or ITER (normal)
  - ITER -> NORM (when count reaches N)
  - NORM -> ROUND -> DONE
  - DONE -> IDLE (when out_ready)
- UNPACK classification:
  - Subnormal inputs are flushed to signed zero.
  - Any NaN input -> canonical qNaN {0, all-ones exp, 1, 0...}, no flag.
  - 0*inf, inf/inf, 0/0 -> qNaN, invalid=1.
  - finite-nonzero/0 -> ±inf, div_by_zero=1.
  - inf*x, inf/x -> ±inf. x/inf -> ±0. zero*x, 0/x -> ±0.
  - Sign is always a_sign ^ b_sign, except NaN results.
- ITER:
  - Mul: N = MAN_W+1 cycles. Produces a 2(MAN_W+1)-bit product.
  - Div: N = MAN_W+3 cycles. Produces MAN_W+3 quotient bits (1 integer bit, MAN_W+2 fraction bits); sticky = (remainder != 0).
- Exponent: signed EXP_W+2-bit arithmetic.
  - Mul: ea+eb-BIAS.
  - Div: ea-eb+BIAS.
  - NORM adjusts by ±1 so the leading 1 sits at the MSB; guard, round and sticky are retained.
- ROUND: round per the macro below. A mantissa carry-out increments the exponent.
  - inexact=1 if guard|round|sticky.
  - Biased exp >= 2^EXP_W-1 -> ±inf, overflow=1, inexact=1.
  - Biased exp <= 0 -> ±0, underflow=1, inexact=1.
- Latency, counted in rising edges from the accept edge to out_valid=1:
  - Special cases: 2.
  - Mul: MAN_W+4.
  - Div: MAN_W+6.
- DONE: out_valid held at 1 with result/flags stable until out_ready=1. out_valid drops the cycle after the handshake; in_ready rises that same cycle. There is no input accept during DONE, so simultaneous in/out handshakes cannot occur.
- Flags are per-operation, not sticky; they are cleared on each accept.

Optional Feature:
FPU_ITER_RNE_EN
- Defined: round-to-nearest-even. Round up when guard && (round|sticky|lsb).
- Undefined: truncation (round toward zero). The ROUND state still exists, so latency is unchanged. inexact is still reported; overflow saturates to ±max finite instead of ±inf.

Test Plan:
1. op=0, a=0x3FF8000000000000 (1.5), b=0x4000000000000000 (2.0) -> result 0x4008000000000000, flags 0, out_valid 56 edges after accept.
2. op=1, a=0x3FF0000000000000, b=0x4008000000000000 (1/3) -> 0x3FD5555555555555, flags=00001, latency 58.
3. op=1, a=0x3FF0000000000000, b=0 -> 0x7FF0000000000000, flags=01000, latency 2. Then 0/0 -> 0x7FF8000000000000, flags=10000.
4. op=0, a=0x7FE0000000000000, b=0x4000000000000000 -> 0x7FF0000000000000, flags=00101. With the macro undefined, the result is 0x7FEFFFFFFFFFFFFF.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result/flags stable, in_ready=0, and in_valid is ignored. Then assert rst during ITER of a new op -> next cycle out_valid=0, in_ready=1, flags=0.
6. EXP_W=5, MAN_W=10: 0x3E00 (1.5) * 0x4000 (2.0) -> 0x4200, latency 14. Also 0x7BFF*0x4000 -> 0x7C00, flags=00101.
